// File: rtl/display_pkg.sv
// Shared types and digit-walking helpers for the seven-segment scan controller.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned VALUE_W    = NUM_DIGITS * NIBBLE_W;

  typedef logic [2:0]            digit_idx_t;
  typedef logic [NIBBLE_W-1:0]   nibble_t;
  typedef logic [NUM_DIGITS-1:0] digit_mask_t;

  typedef struct packed {
    logic [VALUE_W-1:0] value;
    digit_mask_t        dp_mask;
    digit_mask_t        en_mask;
  } disp_data_t;

  localparam disp_data_t DISP_RESET = '{value: '0, dp_mask: '0, en_mask: 8'hFF};

  function automatic digit_idx_t rev3(input digit_idx_t x);
    return {x[0], x[1], x[2]};
  endfunction

  function automatic nibble_t rev4(input nibble_t x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  // Lowest enabled digit strictly above idx; returns idx when none exists.
  function automatic digit_idx_t next_enabled(input digit_mask_t mask, input digit_idx_t idx);
    digit_idx_t res;
    res = idx;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      if (i > int'(idx) && mask[i]) res = 3'(i);
    end
    return res;
  endfunction

  function automatic digit_idx_t first_enabled(input digit_mask_t mask);
    digit_idx_t res;
    res = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      if (mask[i]) res = 3'(i);
    end
    return res;
  endfunction

  function automatic digit_idx_t last_enabled(input digit_mask_t mask);
    digit_idx_t res;
    res = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (mask[i]) res = 3'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Host-side data/strobe inputs and decoder-side outputs of the scan controller.
interface display_scanner_if;
  import display_pkg::*;

  logic               load;
  logic [VALUE_W-1:0] value;
  digit_mask_t        dp_mask;
  digit_mask_t        en_mask;
  nibble_t            num;
  digit_idx_t         sel;
  logic               dp;
  logic               blank;
  logic               pending;
  logic               frame_start;

  modport master (
    output load, value, dp_mask, en_mask,
    input  num, sel, dp, blank, pending, frame_start
  );

  modport slave (
    input  load, value, dp_mask, en_mask,
    output num, sel, dp, blank, pending, frame_start
  );
endinterface

// File: rtl/display_scanner_refresh_tick_gen.sv
// Free-running dwell counter; tick_c is high in the last cycle of each dwell.
module refresh_tick_gen #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_c
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)                count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + CNT_W'(1);
  end

  assign tick_c = (count == LAST);

endmodule

// File: rtl/display_scanner.sv
// Seven-segment scan controller: walks enabled digits, swaps in shadow data only at frame boundaries.
module display_scanner
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  display_scanner_if.slave  bus
);

  disp_data_t active;
  disp_data_t shadow;
  disp_data_t next_active_c;
  digit_idx_t index;
  logic       pending;
  logic       frame_start;
  logic       tick_c;
  logic       boundary_c;

  nibble_t    nib_c;
  nibble_t    num_c;
  digit_idx_t sel_c;
  logic       dp_c;
  logic       blank_c;

  refresh_tick_gen #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_c (tick_c)
  );

  // An empty mask has no last digit, so every tick closes a frame.
  assign boundary_c    = tick_c && ((active.en_mask == '0) ||
                                    (index == last_enabled(active.en_mask)));
  assign next_active_c = pending ? shadow : active;

  always_ff @(posedge clk) begin
    if (rst) begin
      active      <= DISP_RESET;
      shadow      <= '0;
      index       <= '0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary_c;
      if (boundary_c) begin
        active <= next_active_c;
        index  <= first_enabled(next_active_c.en_mask);
      end else if (tick_c) begin
        index  <= next_enabled(active.en_mask, index);
      end
      // A coincident load lands in the shadow after the old shadow was applied.
      if (bus.load) shadow <= '{value: bus.value, dp_mask: bus.dp_mask, en_mask: bus.en_mask};
      pending <= bus.load | (pending & ~boundary_c);
    end
  end

  // Decoder feed, bit-reversed to match the decoder's pin order.
  always_comb begin
    nib_c   = active.value[{index, 2'b00} +: NIBBLE_W];
    num_c   = '0;
    sel_c   = '0;
    dp_c    = 1'b1;
    blank_c = 1'b1;
    if (active.en_mask != '0) begin
      blank_c = 1'b0;
      num_c   = rev4(nib_c);
      sel_c   = rev3(index);
      dp_c    = ~active.dp_mask[index];
    end
  end

  assign bus.num         = num_c;
  assign bus.sel         = sel_c;
  assign bus.dp          = dp_c;
  assign bus.blank       = blank_c;
  assign bus.pending     = pending;
  assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with a 4-cycle dwell; expected values are hand-derived.
module tb_display_scanner;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  display_scanner_if bus ();

  display_scanner #(.REFRESH_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_data(input logic [31:0] v, input logic [7:0] dpm, input logic [7:0] enm);
    bus.load    = 1'b1;
    bus.value   = v;
    bus.dp_mask = dpm;
    bus.en_mask = enm;
    step(1);
    bus.load    = 1'b0;
  endtask

  logic [2:0] sel_tab [8];

  initial begin
    sel_tab = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
    rst         = 1'b1;
    bus.load    = 1'b0;
    bus.value   = '0;
    bus.dp_mask = '0;
    bus.en_mask = '0;
    step(2);
    rst = 1'b0;

    // Reset state and plain full-mask scan
    check("rst_sel",     32'(bus.sel),         32'd0);
    check("rst_num",     32'(bus.num),         32'd0);
    check("rst_dp",      32'(bus.dp),          32'd1);
    check("rst_blank",   32'(bus.blank),       32'd0);
    check("rst_pending", 32'(bus.pending),     32'd0);
    check("rst_fs",      32'(bus.frame_start), 32'd0);
    for (int d = 0; d < 8; d++) begin
      check($sformatf("scan_sel%0d", d), 32'(bus.sel), 32'(sel_tab[d]));
      if (d < 7) step(4);
    end
    step(4);
    check("wrap_fs",  32'(bus.frame_start), 32'd1);
    check("wrap_sel", 32'(bus.sel),         32'd0);
    step(1);
    check("wrap_fs_off", 32'(bus.frame_start), 32'd0);

    // Load mid-frame; applied only at the boundary
    step(7);
    load_data(32'h76543210, 8'h08, 8'hFF);
    check("ld_pending",  32'(bus.pending), 32'd1);
    check("ld_num_old",  32'(bus.num),     32'd0);
    step(22);
    check("ld_pend_hold", 32'(bus.pending),     32'd1);
    check("ld_fs_pre",    32'(bus.frame_start), 32'd0);
    step(1);
    check("ap_fs",      32'(bus.frame_start), 32'd1);
    check("ap_pending", 32'(bus.pending),     32'd0);
    check("ap_sel0",    32'(bus.sel),         32'd0);
    check("ap_num0",    32'(bus.num),         32'b0000);
    check("ap_dp0",     32'(bus.dp),          32'd1);
    step(4);
    check("ap_sel1",    32'(bus.sel),         32'b100);
    check("ap_num1",    32'(bus.num),         32'b1000);
    check("ap_dp1",     32'(bus.dp),          32'd1);
    step(8);
    check("ap_sel3",    32'(bus.sel),         32'b110);
    check("ap_num3",    32'(bus.num),         32'b1100);
    check("ap_dp3",     32'(bus.dp),          32'd0);
    step(16);
    check("ap_sel7",    32'(bus.sel),         32'b111);
    check("ap_num7",    32'(bus.num),         32'b1110);
    check("ap_dp7",     32'(bus.dp),          32'd1);

    // Sparse mask 1010_0101: order 0,2,5,7
    load_data(32'h76543210, 8'h00, 8'hA5);
    step(3);
    check("sp_fs0",  32'(bus.frame_start), 32'd1);
    check("sp_sel0", 32'(bus.sel),         32'b000);
    check("sp_num0", 32'(bus.num),         32'b0000);
    step(4);
    check("sp_sel2", 32'(bus.sel),         32'b010);
    check("sp_num2", 32'(bus.num),         32'b0100);
    step(4);
    check("sp_sel5", 32'(bus.sel),         32'b101);
    check("sp_num5", 32'(bus.num),         32'b1010);
    step(4);
    check("sp_sel7", 32'(bus.sel),         32'b111);
    check("sp_fs7",  32'(bus.frame_start), 32'd0);
    step(4);
    check("sp_fs_wrap",  32'(bus.frame_start), 32'd1);
    check("sp_sel_wrap", 32'(bus.sel),         32'b000);
    step(1);
    check("sp_fs_off", 32'(bus.frame_start), 32'd0);

    // Last load in a frame wins
    load_data(32'h11111111, 8'h00, 8'hFF);
    step(2);
    load_data(32'hCCCCCCCC, 8'h00, 8'hFF);
    step(11);
    check("lw_fs",      32'(bus.frame_start), 32'd1);
    check("lw_pending", 32'(bus.pending),     32'd0);
    check("lw_num",     32'(bus.num),         32'b0011);

    // Load coincident with the boundary tick
    step(2);
    load_data(32'h55555555, 8'h00, 8'hFF);
    step(28);
    load_data(32'h33333333, 8'h00, 8'hFF);
    check("co_fs",      32'(bus.frame_start), 32'd1);
    check("co_num_old", 32'(bus.num),         32'b1010);
    check("co_pending", 32'(bus.pending),     32'd1);
    step(32);
    check("co_fs2",     32'(bus.frame_start), 32'd1);
    check("co_num_new", 32'(bus.num),         32'b1100);
    check("co_pend_clr", 32'(bus.pending),    32'd0);

    // Empty mask: blanked, every tick is a boundary
    load_data(32'hFFFFFFFF, 8'hFF, 8'h00);
    step(31);
    check("bl_blank", 32'(bus.blank),       32'd1);
    check("bl_sel",   32'(bus.sel),         32'd0);
    check("bl_num",   32'(bus.num),         32'd0);
    check("bl_dp",    32'(bus.dp),          32'd1);
    check("bl_fs",    32'(bus.frame_start), 32'd1);
    step(1);
    check("bl_fs_off", 32'(bus.frame_start), 32'd0);
    step(3);
    check("bl_fs_again", 32'(bus.frame_start), 32'd1);

    // Reset mid-frame with pending data
    load_data(32'h76543210, 8'h00, 8'hFF);
    step(3);
    check("rr_fs",    32'(bus.frame_start), 32'd1);
    check("rr_blank", 32'(bus.blank),       32'd0);
    check("rr_sel0",  32'(bus.sel),         32'b000);
    step(20);
    check("rr_sel5",  32'(bus.sel),         32'b101);
    check("rr_num5",  32'(bus.num),         32'b1010);
    load_data(32'hFFFFFFFF, 8'hFF, 8'hFF);
    check("rr_pend_set", 32'(bus.pending), 32'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rr_sel",     32'(bus.sel),         32'd0);
    check("rr_num",     32'(bus.num),         32'd0);
    check("rr_pending", 32'(bus.pending),     32'd0);
    check("rr_dp",      32'(bus.dp),          32'd1);
    check("rr_blank0",  32'(bus.blank),       32'd0);
    check("rr_fs0",     32'(bus.frame_start), 32'd0);
    step(4);
    check("rr_sel1",    32'(bus.sel),         32'b100);
    check("rr_num1",    32'(bus.num),         32'd0);
    step(28);
    check("rr_fs_wrap", 32'(bus.frame_start), 32'd1);
    check("rr_pend_wrap", 32'(bus.pending),   32'd0);
    step(12);
    check("rr_num3",    32'(bus.num),         32'd0);
    check("rr_dp3",     32'(bus.dp),          32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
